regfile_multiport: RTL

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

---
 rtl/regfile_multiport.sv | 68 ++++++
 1 files changed

// File: rtl/regfile_multiport.sv
// regfile_multiport: byte-enabled register file with one write port and N_RD registered read ports.
module regfile_multiport #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int N_RD    = 2,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  output logic                     wr_err,
  input  logic [N_RD-1:0]          rd_en,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic [N_RD-1:0]          rd_valid
);
  localparam int NB = DATA_W / 8;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] be_mask;
  logic [N_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [N_RD-1:0] rd_valid_q;
  logic wr_err_q, wr_err_d, wr_ok;
  logic [ADDR_W-1:0] ra;
  always_comb begin
    be_mask = '0;
    for (int b = 0; b < NB; b++) be_mask[b*8 +: 8] = {8{wr_be[b]}};
    wr_ok = wr_en && (32'(wr_addr) < DEPTH);
    wr_err_d = wr_en && (|wr_be) && !(32'(wr_addr) < DEPTH);
    // clear beats any write; register 0 is pinned to zero when ZERO_R0 is set
    for (int r = 0; r < DEPTH; r++)
      mem_d[r] = (clear || (ZERO_R0 != 0 && r == 0)) ? '0 :
                 (wr_ok && 32'(wr_addr) == r) ? ((mem_q[r] & ~be_mask) | (wr_data & be_mask)) :
                 mem_q[r];
  end
  always_comb begin
    rd_data_d = rd_data_q;
    ra = '0;
    for (int p = 0; p < N_RD; p++) begin
      ra = rd_addr[p*ADDR_W +: ADDR_W];
      if (rd_en[p])
        rd_data_d[p*DATA_W +: DATA_W] = !(32'(ra) < DEPTH) ? '0 :
                                        (BYPASS != 0) ? mem_d[ra] : mem_q[ra];
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q      <= '{default: '0};
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      wr_err_q   <= wr_err_d;
    end
  end
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign wr_err   = wr_err_q;
endmodule
